// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, DBIT data bits LSB first, even parity, one stop bit.
// Presents the received word with parity/framing status and a one-cycle done pulse.
module uart_rx #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16   // 16, 24 or 32
) (
  input  logic            clk,
  input  logic            reset,        // asynchronous, active low
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            parity_err,
  output logic            frame_err
);

  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [4:0]    SLast = 5'(SB_TICK - 1);
  localparam logic [NW-1:0] NLast = NW'(DBIT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e          state_q, state_d;
  logic [4:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            p_q, p_d;
  logic            rx_meta_q, rx_s;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign parity_err   = perr_q;
  assign frame_err    = ferr_q;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s      <= rx_meta_q;
    end
  end

  // FSM, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      p_q     <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      p_q     <= p_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic; counters only move on s_tick.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    p_d     = p_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    unique case (state_q)
      StIdle: begin
        // Level detection, so a held-low line restarts immediately.
        if (!rx_s) begin
          state_d = StStart;
          s_d     = '0;
        end
      end
      StStart: begin
        if (s_tick) begin
          if (s_q == 5'd7) begin
            if (rx_s) begin
              state_d = StIdle;   // glitch, not a start bit
            end else begin
              s_d     = '0;
              n_d     = '0;
              state_d = StData;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      StData: begin
        if (s_tick) begin
          if (s_q == 5'd15) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (n_q == NLast) state_d = StParity;
            else              n_d     = n_q + NW'(1);
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      StParity: begin
        if (s_tick) begin
          if (s_q == 5'd15) begin
            s_d     = '0;
            p_d     = rx_s;
            state_d = StStop;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      StStop: begin
        if (s_tick) begin
          if (s_q == SLast) begin
            dout_d  = b_q;
            perr_d  = (^b_q) ^ p_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames plus hand-written corner sequences,
// with a scoreboard queue popped on every rx_done_tick.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick = 1'b0;
  logic       rx;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       parity_err;
  logic       frame_err;

  logic [1:0] tick_div = 2'd0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic [7:0] ed;
    logic       epe;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];

  int checks = 0;
  int failures = 0;
  int done_count = 0;
  logic prev_done = 1'b0;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .rx           (rx),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .parity_err   (parity_err),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  // One-clock tick every 4 clocks.
  always @(posedge clk) begin
    tick_div <= tick_div + 2'd1;
    s_tick   <= (tick_div == 2'd3);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pop and compare on every completed frame.
  always @(negedge clk) begin
    if (rx_done_tick) begin
      done_count++;
      chk("done_width", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("dout", {24'd0, dout}, {24'd0, e.d});
        chk("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
        chk("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
      end
    end
    prev_done <= rx_done_tick;
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(negedge clk);
      while (!s_tick) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            input logic [7:0] ed, input logic ep, input logic ef);
    exp_t e;
    e.d = ed; e.pe = ep; e.fe = ef;
    sb.push_back(e);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    rx = par;
    wait_ticks(16);
    rx = stp;
    wait_ticks(16);
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while (sb.size() != 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk(name, sb.size(), 32'd0);
  endtask

  initial begin
    int dc0;
    int cyc;
    exp_t e;

    vecs[0] = '{data: 8'hA5, par: 1'b0, ed: 8'hA5, epe: 1'b0};
    vecs[1] = '{data: 8'h07, par: 1'b1, ed: 8'h07, epe: 1'b0};
    vecs[2] = '{data: 8'h80, par: 1'b1, ed: 8'h80, epe: 1'b0};
    vecs[3] = '{data: 8'h3C, par: 1'b1, ed: 8'h3C, epe: 1'b1};
    vecs[4] = '{data: 8'h55, par: 1'b0, ed: 8'h55, epe: 1'b0};

    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    chk("rst_done", {31'd0, rx_done_tick}, 32'd0);
    chk("rst_perr", {31'd0, parity_err}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Table frames, back-to-back with no idle gap.
    for (int i = 0; i < 5; i++)
      send_frame(vecs[i].data, vecs[i].par, 1'b1, vecs[i].ed, vecs[i].epe, 1'b0);
    drain("drain_table");
    chk("table_done_count", done_count, 32'd5);

    // False start: 3 ticks low, then high; nothing must change.
    dc0 = done_count;
    rx = 1'b0;
    wait_ticks(3);
    rx = 1'b1;
    wait_ticks(24);
    chk("glitch_no_done", done_count, dc0);
    chk("glitch_dout", {24'd0, dout}, 32'h55);
    chk("glitch_perr", {31'd0, parity_err}, 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
    drain("drain_5a");

    // Reset during data bit 4 of 0xC3.
    dc0 = done_count;
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx = (8'hC3 >> i) & 8'h01;
      wait_ticks(16);
    end
    rx = 1'b0;          // bit 4 of 0xC3
    wait_ticks(8);
    reset = 1'b0;
    #1;
    chk("midrst_dout", {24'd0, dout}, 32'd0);
    chk("midrst_done", {31'd0, rx_done_tick}, 32'd0);
    chk("midrst_perr", {31'd0, parity_err}, 32'd0);
    chk("midrst_ferr", {31'd0, frame_err}, 32'd0);
    @(negedge clk);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_no_done", done_count, dc0);
    send_frame(8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0);
    drain("drain_c3");

    // Framing error, then line held low: two break frames.
    dc0 = done_count;
    send_frame(8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1);
    e.d = 8'h00; e.pe = 1'b0; e.fe = 1'b1;
    sb.push_back(e);
    sb.push_back(e);
    cyc = 0;
    while (done_count < dc0 + 3 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    chk("break_frames", done_count, dc0 + 3);
    reset = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
